spi_reg_slave: RTL and testbench
================================

Name: spi_reg_slave

Overview:
- SPI responder (peripheral end) for the team's SPI write/read master.
- Holds one DATA_W-bit register.
- Accepts write frames that update the register; answers read frames by shifting the register out on SDI.
- Fully synchronous to the system clock: SCLK, CS_n and SDO are oversampled. It replaces the behavioural register model in the top-level simulation and is synthesizable for a loopback build.

Parameters:
- DATA_W, 16, payload width in bits.
- SYNC_STAGES, 2, synchronizer flops on each of SCLK, CS_n and SDO (minimum 2).
- RESET_VAL, 16'h0000, register value after reset.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset (rst==0 resets).
- SCLK  input  1  SPI clock from master, mode 0, idles low.
- CS_n  input  1  chip select from master, active low.
- SDO  input  1  master data out (slave data in).
- SDI  output  1  slave data out to master.
- reg_q  output  DATA_W  current register contents.
- wr_stb  output  1  one-cycle pulse when a write commits.
- rd_stb  output  1  one-cycle pulse when a read frame completes.
- frame_err  output  1  one-cycle pulse on an aborted or overlong frame.

Behaviour:
- Reset (rst==0): reg_q=RESET_VAL, SDI=0, wr_stb=rd_stb=frame_err=0, synchronizers cleared to CS_n=1/SCLK=0, state=IDLE, bit_cnt=0.
- Input conditioning and timing:
  - SCLK, CS_n and SDO each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized values.
  - SCLK high and low phases must each be ≥ SYNC_STAGES+2 clk cycles; slower is always legal.
- Frame format, MSB first, DATA_W+1 bits: bit 0 = command (1=write, 0=read), then DATA_W data bits.
  - Slave samples SDO on synchronized SCLK rising edges.
  - Slave updates SDI on synchronized SCLK falling edges.
- States:
  - IDLE: wait for CS_n falling edge. Then bit_cnt=0 and go to CMD. If reset released while CS_n is low, stay in IDLE until CS_n has been seen high.
  - CMD: on the first SCLK rise, latch cmd=SDO, bit_cnt=1, go to DATA. On the following SCLK fall, a read loads shift_reg=reg_q and drives SDI=reg_q[DATA_W-1]; a write drives SDI=0.
  - DATA:
    - Each SCLK rise: shift SDO into rx_shift, bit_cnt+1.
    - Each SCLK fall (read): shift shift_reg left and drive the next MSB; after the last bit, SDI=0.
    - bit_cnt saturates at DATA_W+2.
  - Any state except IDLE, on CS_n rising edge: evaluate the frame, then return to IDLE the next cycle.
    - bit_cnt==DATA_W+1 and cmd=1: reg_q<=rx_shift, wr_stb=1 for one cycle.
    - bit_cnt==DATA_W+1 and cmd=0: rd_stb=1.
    - Any other bit_cnt (including 0): frame_err=1, reg_q unchanged.
- Latency: wr_stb and the reg_q update appear SYNC_STAGES+1 clk cycles after the CS_n pin rises.
- SDI is 0 whenever synchronized CS_n is high; there is no tristate.
- SCLK edges while CS_n is high are ignored.
- A CS_n fall in the same cycle as the eval of the previous frame's rise is not possible, because synchronized edges are at least one cycle apart. A CS_n fall seen in IDLE the cycle after eval starts a new frame.
- Reset mid-frame: the frame is discarded with no strobes, and reg_q returns to RESET_VAL.

Optional Feature:
- Macro: SPI_SLAVE_ECHO_EN.
- Defined: during write frames, SDI shifts out the old reg_q, exactly as in a read (full-duplex swap). The master can capture the previous value while writing. Commit rules are unchanged.
- Undefined: SDI=0 throughout write frames.

Test Plan:
- Reset then read frame (cmd=0, 16 clocks): SDI bits = 16'h0000, rd_stb pulses once, reg_q stays 16'h0000.
- Write 16'hA5C3, then read: wr_stb pulses once, reg_q=16'hA5C3, read SDI sequence = 1010_0101_1100_0011, rd_stb=1.
- Aborted write, CS_n rises after cmd plus 8 bits of 16'hFFFF: frame_err pulses, reg_q keeps 16'hA5C3, no wr_stb.
- Overlong write, 18 bits of 16'h1234 plus 1 extra: frame_err pulses, reg_q unchanged.
- rst pulled low mid write frame, released with CS_n still low: no strobes, reg_q=RESET_VAL; the next full write of 16'h0F0F after CS_n high/low commits normally.
- With SPI_SLAVE_ECHO_EN: reg_q=16'h1111, write 16'h2222 → SDI shows 16'h1111, reg_q=16'h2222. Without the macro: SDI stays 0.

Source files
------------

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register responder, oversampled on clk: write frames update reg_q, read frames shift it out on SDI.
// Optional SPI_SLAVE_ECHO_EN: write frames also shift out the previous reg_q (full-duplex swap).
module spi_reg_slave #(
  parameter int                 DATA_W      = 16,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              CS_n,
  input  logic              SDO,
  output logic              SDI,
  output logic [DATA_W-1:0] reg_q,
  output logic              wr_stb,
  output logic              rd_stb,
  output logic              frame_err
);

  localparam int                CNT_W = $clog2(DATA_W + 3);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0]  SAT   = CNT_W'(DATA_W + 2);

`ifdef SPI_SLAVE_ECHO_EN
  localparam logic ECHO = 1'b1;
`else
  localparam logic ECHO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, sdo_sync, fill_q;
  logic                    sclk_d, cs_d, armed;
  logic                    sclk_s, cs_s, sdo_s;
  logic                    sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    cmd_q, sdi_q, tx_en;
  logic [DATA_W-1:0]       rx_shift, shift_reg;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdo_s     = sdo_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign tx_en     = ~cmd_q | ECHO;
  assign SDI       = sdi_q & ~cs_s;

  // fill_q marks when the CS_n chain holds real pin samples rather than its
  // reset value, so a CS_n held low across reset release never looks like a fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sdo_sync  <= '0;
      fill_q    <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_n};
      sdo_sync  <= {sdo_sync[SYNC_STAGES-2:0], SDO};
      fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      armed     <= armed | (fill_q[SYNC_STAGES-1] & cs_s);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall && armed) state_d = CMD;
      CMD:     if (cs_rise) state_d = IDLE;
               else if (sclk_rise) state_d = DATA;
      DATA:    if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q     <= RESET_VAL;
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      frame_err <= 1'b0;
      bit_cnt   <= '0;
      cmd_q     <= 1'b0;
      sdi_q     <= 1'b0;
      rx_shift  <= '0;
      shift_reg <= '0;
    end else begin
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      frame_err <= 1'b0;
      if (state_q == IDLE) begin
        sdi_q <= 1'b0;
        if (cs_fall && armed) bit_cnt <= '0;
      end else if (cs_rise) begin
        // Only a frame of exactly command + DATA_W bits is accepted.
        sdi_q <= 1'b0;
        if (bit_cnt == FULL) begin
          if (cmd_q) begin
            reg_q  <= rx_shift;
            wr_stb <= 1'b1;
          end else begin
            rd_stb <= 1'b1;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end else if (state_q == CMD) begin
        if (sclk_rise) begin
          cmd_q   <= sdo_s;
          bit_cnt <= CNT_W'(1);
        end
      end else begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[DATA_W-2:0], sdo_s};
          if (bit_cnt != SAT) bit_cnt <= bit_cnt + CNT_W'(1);
        end else if (sclk_fall) begin
          if (bit_cnt == CNT_W'(1)) begin
            shift_reg <= reg_q;
            sdi_q     <= tx_en & reg_q[DATA_W-1];
          end else if (bit_cnt >= FULL) begin
            sdi_q <= 1'b0;
          end else begin
            sdi_q     <= tx_en & shift_reg[DATA_W-2];
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: randomized SPI frames, queue-based scoreboard of strobes, reg_q and captured SDI.
module tb_spi_reg_slave;

  localparam int W     = 16;
  localparam int EXP_W = 1 + 3 + W + W;
  localparam logic [2:0] K_WR  = 3'b100;
  localparam logic [2:0] K_RD  = 3'b010;
  localparam logic [2:0] K_ERR = 3'b001;
  localparam logic [W-1:0] RST_VAL = 16'h0000;

  logic         clk, rst, SCLK, CS_n, SDO;
  logic         SDI, wr_stb, rd_stb, frame_err;
  logic [W-1:0] reg_q;

  spi_reg_slave #(.DATA_W(W), .SYNC_STAGES(2), .RESET_VAL(RST_VAL)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CS_n(CS_n), .SDO(SDO),
    .SDI(SDI), .reg_q(reg_q), .wr_stb(wr_stb), .rd_stb(rd_stb), .frame_err(frame_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [W-1:0] model_reg;
  logic [W-1:0] sdi_cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master-side capture of SDI on every SCLK rise inside a frame.
  always @(negedge CS_n) sdi_cap = '0;
  always @(posedge SCLK) if (!CS_n) sdi_cap = {sdi_cap[W-2:0], SDI};

  // Scoreboard monitor: every strobe cycle consumes one expectation.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst && (wr_stb || rd_stb || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {29'd0, wr_stb, rd_stb, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {29'd0, wr_stb, rd_stb, frame_err}, {29'd0, e[2*W +: 3]});
        check("reg_q_after", {16'd0, reg_q}, {16'd0, e[W +: W]});
        if (e[EXP_W-1]) check("sdi_word", {16'd0, sdi_cap}, {16'd0, e[W-1:0]});
      end
    end
  end

  // Reference: a frame counts only with exactly 1 + W bits; writes replace
  // the register, and the master reads back the value held before the frame.
  task automatic expect_frame(input logic cmd, input logic [W-1:0] data, input int nbits);
    logic [W-1:0] sdi_exp;
    if (nbits != W) begin
      exp_q.push_back({1'b0, K_ERR, model_reg, {W{1'b0}}});
    end else if (cmd) begin
`ifdef SPI_SLAVE_ECHO_EN
      sdi_exp = model_reg;
`else
      sdi_exp = '0;
`endif
      model_reg = data;
      exp_q.push_back({1'b1, K_WR, model_reg, sdi_exp});
    end else begin
      exp_q.push_back({1'b1, K_RD, model_reg, model_reg});
    end
  endtask

  task automatic spi_bit(input logic b);
    SDO = b;
    wait_cycles($urandom_range(5, 9));
    SCLK = 1'b1;
    wait_cycles($urandom_range(5, 9));
    SCLK = 1'b0;
  endtask

  // Driver: CS_n low, command bit, nbits data bits MSB first, CS_n high.
  task automatic spi_frame(input logic cmd, input logic [W-1:0] data, input int nbits);
    expect_frame(cmd, data, nbits);
    CS_n = 1'b0;
    wait_cycles($urandom_range(5, 9));
    if (nbits >= 0) spi_bit(cmd);
    for (int i = 0; i < nbits; i++)
      spi_bit(i < W ? data[W-1-i] : 1'($urandom_range(0, 1)));
    wait_cycles($urandom_range(5, 9));
    CS_n = 1'b1;
    wait_cycles(10);
    check("reg_q_model", {16'd0, reg_q}, {16'd0, model_reg});
  endtask

  // Frame with no SCLK at all: CS_n dips low then rises.
  task automatic empty_frame();
    exp_q.push_back({1'b0, K_ERR, model_reg, {W{1'b0}}});
    CS_n = 1'b0;
    wait_cycles(8);
    CS_n = 1'b1;
    wait_cycles(10);
  endtask

  initial begin
    rst = 1'b0; SCLK = 1'b0; CS_n = 1'b1; SDO = 1'b0;
    model_reg = RST_VAL;
    wait_cycles(4);
    check("rst_reg_q", {16'd0, reg_q}, {16'd0, RST_VAL});
    check("rst_strobes", {29'd0, wr_stb, rd_stb, frame_err}, 32'd0);
    check("rst_sdi", {31'd0, SDI}, 32'd0);
    rst = 1'b1;
    wait_cycles(8);

    spi_frame(1'b0, '0, W);
    spi_frame(1'b1, 16'hA5C3, W);
    spi_frame(1'b0, '0, W);
    spi_frame(1'b1, 16'hFFFF, 8);
    spi_frame(1'b1, 16'h1234, W + 1);
    spi_frame(1'b1, 16'h1234, W + 2);
    spi_frame(1'b0, '0, 3);
    empty_frame();
    check("idle_sdi", {31'd0, SDI}, 32'd0);

    // Reset mid write; release with CS_n low, ignore clocks until CS_n seen high.
    CS_n = 1'b0;
    wait_cycles(6);
    spi_bit(1'b1);
    for (int i = 0; i < 8; i++) spi_bit(1'b1);
    rst = 1'b0;
    model_reg = RST_VAL;
    wait_cycles(3);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) spi_bit(1'($urandom_range(0, 1)));
    wait_cycles(6);
    CS_n = 1'b1;
    wait_cycles(10);
    check("mid_rst_reg_q", {16'd0, reg_q}, {16'd0, RST_VAL});
    spi_frame(1'b1, 16'h0F0F, W);
    spi_frame(1'b0, '0, W);

    spi_frame(1'b1, 16'h1111, W);
    spi_frame(1'b1, 16'h2222, W);
    spi_frame(1'b0, '0, W);

    for (int n = 0; n < 30; n++) begin
      int nb;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W + 3)) : W;
      spi_frame(1'($urandom_range(0, 1)), W'($urandom), nb);
    end
    spi_frame(1'b1, W'(16'h8001), W);
    spi_frame(1'b0, '0, W);

    wait_cycles(20);
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("final_sdi", {31'd0, SDI}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
